// File: rtl/fetch_sequencer.sv
// PC and fetch control: sequential/branch/halt next-PC selection, cmp zero flag,
// and a synchronised, debounced push button that releases a halted program.
module fetch_sequencer #(
    parameter int ADDR_WIDTH      = 12,
    parameter int INST_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run_en,
    input  logic [INST_WIDTH-1:0] instr,
    input  logic                  alu_zero,
    input  logic                  button,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  halted,
    output logic                  zero_flag,
    output logic                  btn_pulse
);

    localparam int SYNC_STAGES = 2;
    localparam int CNT_WIDTH   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_JMP  = 4'b0010;
    localparam logic [3:0] OP_JNE  = 4'b0011;
    localparam logic [3:0] OP_JE   = 4'b0100;
    localparam logic [3:0] OP_CMP  = 4'b1000;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   synced;
    logic                   stable_reg;
    logic [CNT_WIDTH-1:0]   cnt_reg;
    logic                   btn_pulse_reg;

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  pc_reg, pc_next;
    logic                   zero_flag_reg, zero_flag_next;

    logic [3:0]             opcode;
    logic [ADDR_WIDTH-1:0]  target;
    logic [ADDR_WIDTH-1:0]  pc_inc;

    assign synced = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], button};
        end
    end

    // The level is accepted only after it has differed from the stable value
    // for DEBOUNCE_CYCLES consecutive cycles; any bounce back restarts the count.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_reg    <= 1'b0;
            cnt_reg       <= '0;
            btn_pulse_reg <= 1'b0;
        end else begin
            btn_pulse_reg <= 1'b0;
            if (synced == stable_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                stable_reg    <= synced;
                cnt_reg       <= '0;
                btn_pulse_reg <= synced;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign opcode = instr[INST_WIDTH-1 -: 4];
    assign target = instr[ADDR_WIDTH-1:0];
    assign pc_inc = pc_reg + ADDR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            pc_reg        <= '0;
            zero_flag_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            zero_flag_reg <= zero_flag_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        zero_flag_next = zero_flag_reg;
        if (run_en) begin
            case (state_reg)
                ST_RUN: begin
                    case (opcode)
                        OP_HALT: state_next = ST_HALT;
                        OP_JMP:  pc_next = target;
                        OP_JNE:  pc_next = zero_flag_reg ? pc_inc : target;
                        OP_JE:   pc_next = zero_flag_reg ? target : pc_inc;
                        OP_CMP: begin
                            zero_flag_next = alu_zero;
                            pc_next        = pc_inc;
                        end
                        default: pc_next = pc_inc;
                    endcase
                end
                ST_HALT: begin
                    // Only a pulse seen while halted resumes; pulses in RUN are dropped.
                    if (btn_pulse_reg) begin
                        pc_next    = pc_inc;
                        state_next = ST_RUN;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    assign pc        = pc_reg;
    assign halted    = (state_reg == ST_HALT);
    assign zero_flag = zero_flag_reg;
    assign btn_pulse = btn_pulse_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a behavioural instruction memory feeds
// instr from pc, and each task drives one scenario with hand-computed results.
module tb_fetch_sequencer;

    localparam int AW = 12;
    localparam int IW = 16;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          run_en = 1'b1;
    logic          alu_zero = 1'b0;
    logic          button = 1'b0;
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic          halted;
    logic          zero_flag;
    logic          btn_pulse;

    logic [IW-1:0] imem [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;

    always #5 clk = ~clk;

    assign instr = imem[pc];

    fetch_sequencer #(
        .ADDR_WIDTH(AW),
        .INST_WIDTH(IW),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run_en(run_en),
        .instr(instr),
        .alu_zero(alu_zero),
        .button(button),
        .pc(pc),
        .halted(halted),
        .zero_flag(zero_flag),
        .btn_pulse(btn_pulse)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        if (btn_pulse === 1'b1) pulse_cnt++;
    endtask

    task automatic fill();
        for (int i = 0; i < (1 << AW); i++) imem[i] = 16'h9000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc: got %0h expected 0", pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b expected 0", halted); end
        checks++; if (zero_flag !== 1'b0) begin errors++; $display("FAIL reset_zf: got %0b expected 0", zero_flag); end
        checks++; if (btn_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %0b expected 0", btn_pulse); end
        reset = 1'b0;
        $display("test_reset done: pc=%0h halted=%0b", pc, halted);
    endtask

    task automatic test_sequential();
        imem[1] = 16'h8000;
        alu_zero = 1'b1;
        tick();
        checks++; if (pc !== 12'h001) begin errors++; $display("FAIL seq_pc1: got %0h expected 1", pc); end
        tick();
        checks++; if (pc !== 12'h002 || zero_flag !== 1'b1) begin errors++; $display("FAIL seq_pc2: got pc=%0h zf=%0b expected pc=2 zf=1", pc, zero_flag); end
        tick();
        checks++; if (pc !== 12'h003) begin errors++; $display("FAIL seq_pc3: got %0h expected 3", pc); end
        do_reset();
        checks++; if (pc !== 12'h000 || zero_flag !== 1'b0) begin errors++; $display("FAIL seq_reset: got pc=%0h zf=%0b expected pc=0 zf=0", pc, zero_flag); end
        imem[1] = 16'h9000;
        $display("test_sequential done: pc=%0h", pc);
    endtask

    task automatic test_branch();
        imem[0]  = 16'h8000;
        imem[1]  = 16'h3003;
        imem[2]  = 16'h200A;
        imem[3]  = 16'h8000;
        imem[4]  = 16'h3003;
        imem[5]  = 16'h4000;
        imem[10] = 16'h8000;
        imem[11] = 16'h4020;
        do_reset();
        alu_zero = 1'b0; tick();
        checks++; if (pc !== 12'h001 || zero_flag !== 1'b0) begin errors++; $display("FAIL br_cmp0: got pc=%0h zf=%0b expected pc=1 zf=0", pc, zero_flag); end
        tick();
        checks++; if (pc !== 12'h003) begin errors++; $display("FAIL br_jne_taken: got %0h expected 3", pc); end
        alu_zero = 1'b1; tick();
        checks++; if (pc !== 12'h004 || zero_flag !== 1'b1) begin errors++; $display("FAIL br_cmp1: got pc=%0h zf=%0b expected pc=4 zf=1", pc, zero_flag); end
        tick();
        checks++; if (pc !== 12'h005) begin errors++; $display("FAIL br_jne_not_taken: got %0h expected 5", pc); end
        tick();
        checks++; if (pc !== 12'h000) begin errors++; $display("FAIL br_je_taken: got %0h expected 0", pc); end
        tick();
        tick();
        checks++; if (pc !== 12'h002) begin errors++; $display("FAIL br_jne_not_taken2: got %0h expected 2", pc); end
        tick();
        checks++; if (pc !== 12'h00A || zero_flag !== 1'b1) begin errors++; $display("FAIL br_jmp: got pc=%0h zf=%0b expected pc=a zf=1", pc, zero_flag); end
        alu_zero = 1'b0; tick();
        checks++; if (pc !== 12'h00B || zero_flag !== 1'b0) begin errors++; $display("FAIL br_cmp2: got pc=%0h zf=%0b expected pc=b zf=0", pc, zero_flag); end
        tick();
        checks++; if (pc !== 12'h00C) begin errors++; $display("FAIL br_je_not_taken: got %0h expected c", pc); end
        $display("test_branch done: pc=%0h zf=%0b", pc, zero_flag);
    endtask

    task automatic test_halt_resume();
        int pulse_at;
        imem[12] = 16'h2008;
        imem[8]  = 16'h0000;
        imem[9]  = 16'h0000;
        tick();
        checks++; if (pc !== 12'h008 || halted !== 1'b0) begin errors++; $display("FAIL halt_jmp: got pc=%0h halted=%0b expected pc=8 halted=0", pc, halted); end
        tick();
        checks++; if (pc !== 12'h008 || halted !== 1'b1) begin errors++; $display("FAIL halt_enter: got pc=%0h halted=%0b expected pc=8 halted=1", pc, halted); end
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++; if (pc !== 12'h008 || halted !== 1'b1) begin errors++; $display("FAIL halt_hold: cycle %0d got pc=%0h halted=%0b expected pc=8 halted=1", i, pc, halted); end
        end
        pulse_cnt = 0;
        pulse_at = -1;
        button = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (btn_pulse === 1'b1 && pulse_at < 0) pulse_at = i;
            if (pulse_at > 0 && i == pulse_at + 1) begin
                checks++; if (pc !== 12'h009 || halted !== 1'b0) begin errors++; $display("FAIL resume: got pc=%0h halted=%0b expected pc=9 halted=0", pc, halted); end
            end
        end
        checks++; if (pulse_at != 6) begin errors++; $display("FAIL pulse_latency: got %0d expected 6", pulse_at); end
        checks++; if (pulse_cnt != 1) begin errors++; $display("FAIL hold_one_pulse: got %0d expected 1", pulse_cnt); end
        checks++; if (pc !== 12'h009 || halted !== 1'b1) begin errors++; $display("FAIL one_resume: got pc=%0h halted=%0b expected pc=9 halted=1", pc, halted); end
        button = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (pulse_cnt != 1 || pc !== 12'h009) begin errors++; $display("FAIL release_no_pulse: got pulses=%0d pc=%0h expected pulses=1 pc=9", pulse_cnt, pc); end
        $display("test_halt_resume done: pc=%0h pulse_at=%0d pulses=%0d", pc, pulse_at, pulse_cnt);
    endtask

    task automatic test_debounce_glitch();
        pulse_cnt = 0;
        button = 1'b1;
        for (int i = 0; i < DB - 1; i++) tick();
        button = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (pulse_cnt != 0) begin errors++; $display("FAIL glitch_pulse: got %0d expected 0", pulse_cnt); end
        checks++; if (pc !== 12'h009 || halted !== 1'b1) begin errors++; $display("FAIL glitch_pc: got pc=%0h halted=%0b expected pc=9 halted=1", pc, halted); end
        $display("test_debounce_glitch done: pulses=%0d pc=%0h", pulse_cnt, pc);
    endtask

    task automatic test_halt_run_en();
        pulse_cnt = 0;
        run_en = 1'b0;
        button = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (pulse_cnt != 1) begin errors++; $display("FAIL gated_pulse_seen: got %0d expected 1", pulse_cnt); end
        checks++; if (pc !== 12'h009 || halted !== 1'b1) begin errors++; $display("FAIL gated_halt: got pc=%0h halted=%0b expected pc=9 halted=1", pc, halted); end
        run_en = 1'b1;
        button = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (pc !== 12'h009 || halted !== 1'b1) begin errors++; $display("FAIL lost_pulse: got pc=%0h halted=%0b expected pc=9 halted=1", pc, halted); end
        $display("test_halt_run_en done: pc=%0h halted=%0b", pc, halted);
    endtask

    task automatic test_reset_in_halt();
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL pre_reset_halted: got %0b expected 1", halted); end
        do_reset();
        checks++; if (pc !== 12'h000 || halted !== 1'b0) begin errors++; $display("FAIL reset_in_halt: got pc=%0h halted=%0b expected pc=0 halted=0", pc, halted); end
        $display("test_reset_in_halt done: pc=%0h halted=%0b", pc, halted);
    endtask

    task automatic test_run_gating();
        fill();
        imem[3] = 16'h8000;
        alu_zero = 1'b1;
        do_reset();
        tick(); tick(); tick();
        checks++; if (pc !== 12'h003 || zero_flag !== 1'b0) begin errors++; $display("FAIL gate_pre: got pc=%0h zf=%0b expected pc=3 zf=0", pc, zero_flag); end
        run_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (pc !== 12'h003 || zero_flag !== 1'b0) begin errors++; $display("FAIL gate_frozen: cycle %0d got pc=%0h zf=%0b expected pc=3 zf=0", i, pc, zero_flag); end
        end
        run_en = 1'b1;
        tick();
        checks++; if (pc !== 12'h004 || zero_flag !== 1'b1) begin errors++; $display("FAIL gate_resume: got pc=%0h zf=%0b expected pc=4 zf=1", pc, zero_flag); end
        $display("test_run_gating done: pc=%0h zf=%0b", pc, zero_flag);
    endtask

    task automatic test_press_in_run();
        fill();
        imem[30] = 16'h0000;
        do_reset();
        pulse_cnt = 0;
        button = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (pc !== 12'h00A || pulse_cnt != 1 || halted !== 1'b0) begin errors++; $display("FAIL run_press: got pc=%0h pulses=%0d halted=%0b expected pc=a pulses=1 halted=0", pc, pulse_cnt, halted); end
        button = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++; if (pc !== 12'h01E || halted !== 1'b0) begin errors++; $display("FAIL run_reach_halt: got pc=%0h halted=%0b expected pc=1e halted=0", pc, halted); end
        tick();
        checks++; if (pc !== 12'h01E || halted !== 1'b1) begin errors++; $display("FAIL run_halt_enter: got pc=%0h halted=%0b expected pc=1e halted=1", pc, halted); end
        for (int i = 0; i < 10; i++) tick();
        checks++; if (pc !== 12'h01E || halted !== 1'b1) begin errors++; $display("FAIL pulse_not_remembered: got pc=%0h halted=%0b expected pc=1e halted=1", pc, halted); end
        $display("test_press_in_run done: pc=%0h halted=%0b", pc, halted);
    endtask

    task automatic test_wrap();
        fill();
        imem[0] = 16'h2FFF;
        do_reset();
        tick();
        checks++; if (pc !== 12'hFFF) begin errors++; $display("FAIL wrap_jmp: got %0h expected fff", pc); end
        tick();
        checks++; if (pc !== 12'h000) begin errors++; $display("FAIL wrap_inc: got %0h expected 0", pc); end
        $display("test_wrap done: pc=%0h", pc);
    endtask

    initial begin
        fill();
        test_reset();
        test_sequential();
        test_branch();
        test_halt_resume();
        test_debounce_glitch();
        test_halt_run_en();
        test_reset_in_halt();
        test_run_gating();
        test_press_in_run();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Program-counter and fetch-control stage that drives the address input of the instruction memory and consumes the 16-bit instruction word it returns. It computes the next PC each cycle: sequential, jmp/je/jne, or hold on halt. It owns the zero flag written by cmp. It also debounces the board push button that releases a halted program.

Parameters:
ADDR_WIDTH, 12, PC / instruction-memory address width
INST_WIDTH, 16, instruction word width; opcode = instr[15:12], target = instr[ADDR_WIDTH-1:0]
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a button level change (benches override to 4)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
run_en  in  1  advance enable; when 0 all PC/flag/FSM state holds (debouncer keeps running)
instr  in  INST_WIDTH  instruction word read asynchronously at address pc
alu_zero  in  1  ALU zero result for the current instruction
button  in  1  raw asynchronous push button, active-high
pc  out  ADDR_WIDTH  current fetch address to instruction memory
halted  out  1  1 while in HALT state
zero_flag  out  1  registered compare flag
btn_pulse  out  1  one-cycle pulse on debounced button press (debug/VGA)

Behaviour:
- Reset (synchronous, takes priority over everything, including mid-halt and mid-debounce): pc=0, state=RUN, zero_flag=0, halted=0, btn_pulse=0, sync flops=0, stable level=0, debounce counter=0.
- Opcode decode uses instr[15:12]: 0000 halt, 0010 jmp, 0011 jne, 0100 je, 1000 cmp. All other opcodes are sequential.
- Button path: 2-flop synchronizer, then debouncer. Counter increments while synced != stable and clears when they match. When the counter reaches DEBOUNCE_CYCLES-1 while still differing, stable<=synced and the counter clears. btn_pulse=1 for exactly the one cycle after stable goes 0->1. Press-to-pulse latency = 2 sync cycles + DEBOUNCE_CYCLES. Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- FSM states RUN and HALT. Everything below applies only when run_en=1.
- RUN, opcode halt: pc holds, state becomes HALT next cycle, halted=1.
- RUN, jmp: pc <= target.
- RUN, je: pc <= target if zero_flag=1, else pc+1.
- RUN, jne: pc <= target if zero_flag=0, else pc+1.
- RUN, cmp: zero_flag <= alu_zero and pc <= pc+1.
- zero_flag changes only on cmp. A branch directly after cmp sees the newly latched value.
- RUN, other opcodes: pc <= pc+1.
- HALT: pc and zero_flag hold. On btn_pulse=1, pc <= pc+1 and state returns to RUN (halted=0 next cycle). A pulse arriving in RUN is ignored and not remembered.
- If btn_pulse and run_en=0 coincide in HALT, the pulse is lost and the program stays halted.
- PC arithmetic is modulo 2^ADDR_WIDTH: 0xFFF+1 = 0x000. Jump target is zero-extended low ADDR_WIDTH bits.
- Latency: pc changes one clock after the instruction is presented. There is no pipelining and no bubbles.

Test Plan:
- Reset then sequential: instr stream of non-control opcodes (e.g. 0x9000), run_en=1 -> pc = 0,1,2,3 on successive cycles. Assert reset at pc=3 -> pc=0, zero_flag=0 next cycle.
- Branch flag: cmp with alu_zero=0, then jne 0x003 -> pc=3. Repeat cmp with alu_zero=1, then jne -> pc+1. je 0x000 after the zero cmp -> pc=0. jmp 0x00A -> pc=10 regardless of flag.
- Halt/resume: present halt at pc=8 -> pc stays 8, halted=1 for 100 cycles. Press button for 10 cycles (DEBOUNCE_CYCLES=4) -> one btn_pulse, pc=9, halted=0.
- Debounce: 3-cycle button glitch in HALT -> no btn_pulse, pc stays 8. Hold the button through a halt-exit -> exactly one pulse and exactly one resume. A press while in RUN -> pc unaffected.
- run_en gating: run_en=0 for 5 cycles mid-program -> pc and zero_flag frozen, then resume at the same pc. In HALT, a pulse with run_en=0 -> remains halted.
- Wrap and reset-in-halt: pc=0xFFF with a sequential opcode -> pc=0x000. Reset asserted while halted -> pc=0, halted=0 next cycle.
